// File: rtl/cpu8_control_core.sv
// 8-bit accumulator CPU: fetch/decode/execute FSM and datapath mastering the memory bus.
// Read data arrives one cycle after the address is presented; writes occur in a single store state.
module cpu8_control_core #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address,
  output logic [7:0] to_memory,
  output logic       write,
  input  logic [7:0] from_memory,
  output logic [7:0] pc_out,
  output logic [7:0] ir_out,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [3:0] ccr_out
);

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD_AB  = 8'h42;
  localparam logic [7:0] OP_SUB_AB  = 8'h43;
  localparam logic [7:0] OP_AND_AB  = 8'h44;
  localparam logic [7:0] OP_OR_AB   = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  typedef enum logic [3:0] {
    ST_F0, ST_F1, ST_F2, ST_D3, ST_S4, ST_S5, ST_S6, ST_S7, ST_S8
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] mar;
  logic [7:0] ir;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] ccr;

  logic is_ld_imm;
  logic is_ld_dir;
  logic is_st;
  logic is_alu;
  logic is_br;
  logic dst_b;
  logic taken;

  logic [7:0] alu_res;
  logic [8:0] alu_sum;
  logic       alu_v;
  logic       alu_c;

  // Instruction class decode from the IR
  always_comb begin
    is_ld_imm = (ir == OP_LDA_IMM) || (ir == OP_LDB_IMM);
    is_ld_dir = (ir == OP_LDA_DIR) || (ir == OP_LDB_DIR);
    is_st     = (ir == OP_STA_DIR) || (ir == OP_STB_DIR);
    is_alu    = (ir == OP_ADD_AB) || (ir == OP_SUB_AB) || (ir == OP_AND_AB) ||
                (ir == OP_OR_AB)  || (ir == OP_INCA);
    is_br     = (ir == OP_BRA) || (ir == OP_BEQ) || (ir == OP_BMI);
    dst_b     = (ir == OP_LDB_IMM) || (ir == OP_LDB_DIR);
    taken     = (ir == OP_BRA) || ((ir == OP_BEQ) && ccr[2]) || ((ir == OP_BMI) && ccr[3]);
  end

  // ALU result and V/C flags; ccr layout is {N,Z,V,C}
  always_comb begin
    alu_sum = 9'h000;
    alu_res = a;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (ir)
      OP_ADD_AB: begin
        alu_sum = {1'b0, a} + {1'b0, b};
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_v   = (a[7] == b[7]) && (alu_res[7] != a[7]);
      end
      OP_SUB_AB: begin
        alu_res = a - b;
        alu_c   = (a < b);
        alu_v   = (a[7] != b[7]) && (alu_res[7] != a[7]);
      end
      OP_AND_AB: alu_res = a & b;
      OP_OR_AB:  alu_res = a | b;
      OP_INCA: begin
        alu_sum = {1'b0, a} + 9'd1;
        alu_res = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_v   = !a[7] && alu_res[7];
      end
      default: alu_res = a;
    endcase
  end

  // Control FSM and datapath registers; one register update per state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_F0;
      pc    <= RESET_PC;
      mar   <= RESET_PC;
      ir    <= 8'h00;
      a     <= 8'h00;
      b     <= 8'h00;
      ccr   <= 4'h0;
    end else begin
      case (state)
        ST_F0: begin
          mar   <= pc;
          state <= ST_F1;
        end
        ST_F1: begin
          pc    <= pc + 8'd1;
          state <= ST_F2;
        end
        ST_F2: begin
          ir    <= from_memory;
          state <= ST_D3;
        end
        ST_D3: begin
          if (is_ld_imm || is_ld_dir || is_st || is_alu || is_br) state <= ST_S4;
          else                                                     state <= ST_F0;
        end
        ST_S4: begin
          if (is_alu) begin
            a     <= alu_res;
            ccr   <= {alu_res[7], (alu_res == 8'h00), alu_v, alu_c};
            state <= ST_F0;
          end else begin
            mar   <= pc;
            state <= ST_S5;
          end
        end
        ST_S5: begin
          // Branches leave the PC alone here; the operand fetch decides it in S6
          if (!is_br) pc <= pc + 8'd1;
          state <= ST_S6;
        end
        ST_S6: begin
          if (is_ld_imm) begin
            if (dst_b) b <= from_memory;
            else       a <= from_memory;
            ccr   <= {from_memory[7], (from_memory == 8'h00), ccr[1:0]};
            state <= ST_F0;
          end else if (is_ld_dir || is_st) begin
            mar   <= from_memory;
            state <= ST_S7;
          end else begin
            pc    <= taken ? from_memory : pc + 8'd1;
            state <= ST_F0;
          end
        end
        ST_S7: begin
          if (is_st) state <= ST_F0;
          else       state <= ST_S8;
        end
        ST_S8: begin
          if (dst_b) b <= from_memory;
          else       a <= from_memory;
          ccr   <= {from_memory[7], (from_memory == 8'h00), ccr[1:0]};
          state <= ST_F0;
        end
        default: state <= ST_F0;
      endcase
    end
  end

  // Write strobe and data decode straight from the state register so reset clears them at once
  always_comb begin
    write     = 1'b0;
    to_memory = 8'h00;
    if ((state == ST_S7) && is_st) begin
      write     = 1'b1;
      to_memory = (ir == OP_STB_DIR) ? b : a;
    end
  end

  assign address = mar;
  assign pc_out  = pc;
  assign ir_out  = ir;
  assign a_out   = a;
  assign b_out   = b;
  assign ccr_out = ccr;

endmodule

// File: tb/tb_cpu8_control_core.sv
// Bench for cpu8_control_core: 256-byte synchronous memory model, vector table and store/reset sequences.
module tb_cpu8_control_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] address;
  logic [7:0] to_memory;
  logic       write;
  logic [7:0] from_memory;
  logic [7:0] pc_out;
  logic [7:0] ir_out;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [3:0] ccr_out;

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu8_control_core #(.RESET_PC(8'h00)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .to_memory(to_memory),
    .write(write),
    .from_memory(from_memory),
    .pc_out(pc_out),
    .ir_out(ir_out),
    .a_out(a_out),
    .b_out(b_out),
    .ccr_out(ccr_out)
  );

  // Synchronous memory: data for the address held in cycle N appears in cycle N+1
  always @(posedge clk) begin
    if (ld_en)      mem[ld_addr] <= ld_data;
    else if (write) mem[address] <= to_memory;
    from_memory <= mem[address];
  end

  typedef struct {
    logic [63:0] prog;
    logic [7:0]  seg_addr;
    logic [15:0] seg;
    int          cycles;
    logic [7:0]  pc;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  ccr;
  } vec_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%02h expected=0x%02h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] ad, input logic [7:0] d);
    ld_addr = ad;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds reset while the memory image is rebuilt, releases it on a falling edge
  task automatic load_and_reset(input logic [63:0] prog, input logic [7:0] sa, input logic [15:0] seg);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    for (int i = 0; i < 8; i++) poke(8'(i), prog[63-8*i -: 8]);
    poke(sa, seg[15:8]);
    poke(sa + 8'd1, seg[7:0]);
    reset = 1'b0;
  endtask

  initial begin
    int wcount;
    int wedge;
    int bad_td;

    vecs[0]  = '{64'h86AA_0000_0000_0000, 8'h80, 16'h0000,  7, 8'h02, 8'hAA, 8'h00, 4'h8};
    vecs[1]  = '{64'h867F_8801_4200_0000, 8'h80, 16'h0000, 19, 8'h05, 8'h80, 8'h01, 4'hA};
    vecs[2]  = '{64'h867F_8801_4243_0000, 8'h80, 16'h0000, 24, 8'h06, 8'h7F, 8'h01, 4'h2};
    vecs[3]  = '{64'h86F0_883C_4400_0000, 8'h80, 16'h0000, 19, 8'h05, 8'h30, 8'h3C, 4'h0};
    vecs[4]  = '{64'h8600_8800_4500_0000, 8'h80, 16'h0000, 19, 8'h05, 8'h00, 8'h00, 4'h4};
    vecs[5]  = '{64'h86FF_4600_0000_0000, 8'h80, 16'h0000, 12, 8'h03, 8'h00, 8'h00, 4'h5};
    vecs[6]  = '{64'h867F_4600_0000_0000, 8'h80, 16'h0000, 12, 8'h03, 8'h80, 8'h00, 4'hA};
    vecs[7]  = '{64'h8601_8802_4300_0000, 8'h80, 16'h0000, 19, 8'h05, 8'hFF, 8'h02, 4'h9};
    vecs[8]  = '{64'h8601_2010_0000_0000, 8'h10, 16'h2340, 21, 8'h12, 8'h01, 8'h00, 4'h0};
    vecs[9]  = '{64'h8600_2010_0000_0000, 8'h10, 16'h2340, 21, 8'h40, 8'h00, 8'h00, 4'h4};
    vecs[10] = '{64'h20FE_0000_0000_0000, 8'hFE, 16'h2000, 14, 8'h00, 8'h00, 8'h00, 4'h0};
    vecs[11] = '{64'h8680_2130_0000_0000, 8'h80, 16'h0000, 14, 8'h30, 8'h80, 8'h00, 4'h8};
    vecs[12] = '{64'h8601_2130_0000_0000, 8'h80, 16'h0000, 14, 8'h04, 8'h01, 8'h00, 4'h0};
    vecs[13] = '{64'h8705_0000_00C3_0000, 8'h80, 16'h0000,  9, 8'h02, 8'hC3, 8'h00, 4'h8};
    vecs[14] = '{64'hFF86_1200_0000_0000, 8'h80, 16'h0000, 11, 8'h03, 8'h12, 8'h00, 4'h0};
    vecs[15] = '{64'h86FF_4688_8000_0000, 8'h80, 16'h0000, 19, 8'h05, 8'h00, 8'h80, 4'h9};
    vecs[16] = '{64'h8906_0000_0000_0100, 8'h80, 16'h0000,  9, 8'h02, 8'h00, 8'h01, 4'h0};

    // Reset state and fetch timing
    reset = 1'b1;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    poke(8'h00, 8'h86);
    poke(8'h01, 8'hAA);
    chk("rst_address", address, 8'h00);
    chk("rst_write", {7'd0, write}, 8'h00);
    chk("rst_to_memory", to_memory, 8'h00);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_ir", ir_out, 8'h00);
    chk("rst_a", a_out, 8'h00);
    chk("rst_b", b_out, 8'h00);
    chk("rst_ccr", {4'h0, ccr_out}, 8'h00);
    reset = 1'b0;
    step(2);
    chk("fetch_pc_inc", pc_out, 8'h01);
    chk("fetch_mar", address, 8'h00);
    step(1);
    chk("fetch_ir", ir_out, 8'h86);
    step(4);
    chk("ldi_a", a_out, 8'hAA);
    chk("ldi_pc", pc_out, 8'h02);
    chk("ldi_ccr", {4'h0, ccr_out}, 8'h08);
    step(1);
    chk("next_fetch_address", address, 8'h02);

    // Vector table: program image, cycle count, expected architectural state
    for (int i = 0; i < int'(NVEC); i++) begin
      load_and_reset(vecs[i].prog, vecs[i].seg_addr, vecs[i].seg);
      step(vecs[i].cycles);
      chk($sformatf("v%0d_pc", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_a", i), a_out, vecs[i].a);
      chk($sformatf("v%0d_b", i), b_out, vecs[i].b);
      chk($sformatf("v%0d_ccr", i), {4'h0, ccr_out}, {4'h0, vecs[i].ccr});
    end

    // Store: one write cycle to 0xE0, then read it back into B
    load_and_reset(64'h8655_96E0_89E0_0000, 8'h80, 16'h0000);
    wcount = 0;
    wedge  = -1;
    bad_td = 0;
    for (int e = 1; e <= 15; e++) begin
      step(1);
      if (write) begin
        wcount++;
        wedge = e;
        chk("st_address", address, 8'hE0);
        chk("st_data", to_memory, 8'h55);
      end else if (to_memory !== 8'h00) begin
        bad_td++;
      end
    end
    chk("st_write_count", 8'(wcount), 8'd1);
    chk("st_write_cycle", 8'(wedge), 8'd14);
    chk("st_idle_data_zero", 8'(bad_td), 8'd0);
    chk("st_mem", mem[8'hE0], 8'h55);
    chk("st_ccr_kept", {4'h0, ccr_out}, 8'h00);
    step(9);
    chk("ldb_dir_b", b_out, 8'h55);
    chk("ldb_dir_pc", pc_out, 8'h06);

    // Reset asserted between edges during the store write state
    load_and_reset(64'h8655_96E0_0000_0000, 8'h80, 16'h0000);
    step(14);
    chk("abort_write_before", {7'd0, write}, 8'h01);
    #2 reset = 1'b1;
    #1;
    chk("abort_write_comb", {7'd0, write}, 8'h00);
    chk("abort_data_comb", to_memory, 8'h00);
    @(negedge clk);
    chk("abort_no_mem_write", mem[8'hE0], 8'h00);
    chk("abort_pc", pc_out, 8'h00);
    chk("abort_address", address, 8'h00);
    reset = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
